// File: rtl/iterative_divider_if.sv
// rtl/iterative_divider_if.sv - operand/result handshake bundle for iterative_divider
interface iterative_divider_if #(
  parameter int DATA_LEN = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] dividend;
  logic [DATA_LEN-1:0] divisor;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] quotient;
  logic [DATA_LEN-1:0] remainder;
  logic                div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multi-cycle radix-2 restoring divider, one op in flight
module iterative_divider #(
  parameter int DATA_LEN = 32,
  parameter bit SIGNED   = 1'b1
) (
  input logic               clk,
  input logic               reset,
  iterative_divider_if.slave bus
);
  localparam int N  = DATA_LEN;
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    dvd_q, dvd_d;
  logic [N-1:0]    dvs_q, dvs_d;
  logic [N:0]      rem_q, rem_d;
  logic [CW-1:0]   count_q, count_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [N-1:0]    quotient_q, quotient_d;
  logic [N-1:0]    remainder_q, remainder_d;
  logic            dbz_q, dbz_d;

  logic            dvd_neg, dvs_neg;
  logic [N-1:0]    dvd_mag, dvs_mag;
  logic [N+1:0]    shift;
  logic [N:0]      sub;
  logic            ge;

  always_comb begin
    dvd_neg = SIGNED && bus.dividend[N-1];
    dvs_neg = SIGNED && bus.divisor[N-1];
    // Negating MIN yields MIN, whose unsigned reading is the correct magnitude.
    dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
    dvs_mag = dvs_neg ? -bus.divisor  : bus.divisor;

    shift = {rem_q, dvd_q[N-1]};
    ge    = shift >= {2'b00, dvs_q};
    sub   = shift[N:0] - {1'b0, dvs_q};

    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    count_d     = count_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.divisor == '0) begin
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            dvd_d   = dvd_mag;
            dvs_d   = dvs_mag;
            rem_d   = '0;
            count_d = CW'(N - 1);
            q_neg_d = dvd_neg ^ dvs_neg;
            r_neg_d = dvd_neg;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Quotient bits shift into the vacated low end of the dividend register.
        rem_d   = ge ? sub : shift[N:0];
        dvd_d   = {dvd_q[N-2:0], ge};
        count_d = count_q - 1'b1;
        if (count_q == '0) state_d = FIX;
      end
      FIX: begin
        quotient_d  = q_neg_q ? -dvd_q : dvd_q;
        remainder_d = r_neg_q ? -rem_q[N-1:0] : rem_q[N-1:0];
        dbz_d       = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      count_q     <= count_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule
